// File: rtl/axilite_slave_regport.sv
// axilite_slave_regport
// AXI4-Lite responder that turns one AXI transaction at a time into a
// level request / ack access on a simple register port feeding a register file.
// Writes win over reads. Addresses at or above REG_SPACE_BYTES are answered
// with SLVERR and never reach the register port.
// Build option: define AXILITE_SLV_TIMEOUT_EN to abandon an access that sees no
// reg_ack within TIMEOUT_CYC cycles; it is then answered with SLVERR, rdata 0.

module axilite_slave_regport #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned REG_SPACE_BYTES = 'h100,
  parameter int unsigned TIMEOUT_CYC     = 16
) (
  input  logic                aclk,
  input  logic                areset,
  // write address channel
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  // write data channel
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  // write response channel
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  // read address channel
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  // read data channel
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // register port
  output logic                reg_wr_en,
  output logic                reg_rd_en,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_wstrb,
  input  logic                reg_ack,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_err
);

  localparam int unsigned       STRB_W     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);
  localparam logic [ADDR_W-1:0] SPACE_END  = ADDR_W'(REG_SPACE_BYTES);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    WR_RSP,
    RD_ACC,
    RD_RSP
  } state_t;

  state_t state;
  logic   accept_en;   // high only while IDLE and out of reset: gates all readies
  logic   aw_held;     // write address captured, waiting for write data
  logic   w_held;      // write data captured, waiting for write address
  logic   aw_oor;      // captured write address lies outside the register space

  logic aw_take;
  logic w_take;
  logic ar_take;
  logic aw_have;
  logic w_have;
  logic wr_go;
  logic wr_oor;
  logic ar_oor;
  logic acc_timeout;

  // NOTE: handshake qualifiers are plain continuous assigns -- every path is
  // driven in every cycle, so no storage (latch) can be inferred for them.
  assign s_axi_awready = accept_en && !aw_held;
  assign s_axi_wready  = accept_en && !w_held;
  assign s_axi_arready = accept_en && !aw_held && !w_held &&
                         !s_axi_awvalid && !s_axi_wvalid;

  assign aw_take = s_axi_awvalid && s_axi_awready;
  assign w_take  = s_axi_wvalid  && s_axi_wready;
  assign ar_take = s_axi_arvalid && s_axi_arready;

  // A half is "had" once held from an earlier cycle or taken this cycle, so a
  // write completing its last half launches the access on that same edge.
  assign aw_have = aw_held || aw_take;
  assign w_have  = w_held  || w_take;
  assign wr_go   = aw_have && w_have;
  assign wr_oor  = aw_take ? (s_axi_awaddr >= SPACE_END) : aw_oor;
  assign ar_oor  = s_axi_araddr >= SPACE_END;

`ifdef AXILITE_SLV_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;

  // Last unacknowledged cycle of an access: the access is abandoned on this edge.
  assign acc_timeout = (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !reg_ack;

  // Count access cycles without reg_ack; cleared whenever no access is open.
  always_ff @(posedge aclk) begin
    if (areset || (state != WR_ACC && state != RD_ACC)) begin
      to_cnt <= '0;
    end else if (!reg_ack) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cyc;

  // Without the timeout an access waits for reg_ack indefinitely.
  assign acc_timeout        = 1'b0;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // Transaction FSM with all channel and register-port outputs registered.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the values from before this clock edge.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      accept_en    <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_oor       <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
      reg_wr_en    <= 1'b0;
      reg_rd_en    <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_wstrb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          accept_en <= 1'b1;
          if (aw_take) begin
            reg_addr <= s_axi_awaddr & ALIGN_MASK;
            aw_oor   <= s_axi_awaddr >= SPACE_END;
          end
          if (w_take) begin
            reg_wdata <= s_axi_wdata;
            reg_wstrb <= s_axi_wstrb;
          end
          if (wr_go) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            accept_en <= 1'b0;
            if (wr_oor) begin
              state        <= WR_RSP;
              s_axi_bresp  <= RESP_SLVERR;
              s_axi_bvalid <= 1'b1;
            end else begin
              state     <= WR_ACC;
              reg_wr_en <= 1'b1;
            end
          end else begin
            aw_held <= aw_have;
            w_held  <= w_have;
            // ar_take is never true while any write half is pending or offered.
            if (ar_take) begin
              reg_addr  <= s_axi_araddr & ALIGN_MASK;
              accept_en <= 1'b0;
              if (ar_oor) begin
                state        <= RD_RSP;
                s_axi_rresp  <= RESP_SLVERR;
                s_axi_rdata  <= '0;
                s_axi_rvalid <= 1'b1;
              end else begin
                state     <= RD_ACC;
                reg_rd_en <= 1'b1;
              end
            end
          end
        end

        WR_ACC: begin
          if (reg_ack) begin
            reg_wr_en    <= 1'b0;
            s_axi_bresp  <= reg_err ? RESP_SLVERR : RESP_OKAY;
            s_axi_bvalid <= 1'b1;
            state        <= WR_RSP;
          end else if (acc_timeout) begin
            reg_wr_en    <= 1'b0;
            s_axi_bresp  <= RESP_SLVERR;
            s_axi_bvalid <= 1'b1;
            state        <= WR_RSP;
          end
        end

        WR_RSP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            accept_en    <= 1'b1;
            state        <= IDLE;
          end
        end

        RD_ACC: begin
          if (reg_ack) begin
            reg_rd_en    <= 1'b0;
            s_axi_rdata  <= reg_rdata;
            s_axi_rresp  <= reg_err ? RESP_SLVERR : RESP_OKAY;
            s_axi_rvalid <= 1'b1;
            state        <= RD_RSP;
          end else if (acc_timeout) begin
            reg_rd_en    <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_SLVERR;
            s_axi_rvalid <= 1'b1;
            state        <= RD_RSP;
          end
        end

        RD_RSP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            accept_en    <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          accept_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_slave_regport.sv
// tb_axilite_slave_regport
// Directed and randomized AXI4-Lite traffic against axilite_slave_regport.
// A register-file agent answers the register port with programmable ack delay,
// error and suppression; a word-array model of the register space supplies
// every expected response. Timeout checks apply when AXILITE_SLV_TIMEOUT_EN
// is defined for the build.

module tb_axilite_slave_regport;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = DATA_W / 8;
  localparam int SPACE       = 'h100;
  localparam int TIMEOUT_CYC = 16;
  localparam int N_WORDS     = SPACE / STRB_W;

  logic              aclk = 1'b0;
  logic              areset;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic [STRB_W-1:0] s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [STRB_W-1:0] reg_wstrb;
  logic              reg_ack;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_err;

  axilite_slave_regport #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .REG_SPACE_BYTES(SPACE),
    .TIMEOUT_CYC    (TIMEOUT_CYC)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_wstrb    (reg_wstrb),
    .reg_ack      (reg_ack),
    .reg_rdata    (reg_rdata),
    .reg_err      (reg_err)
  );

  always #5 aclk = ~aclk;

  // Cycle index; inside cycle k (after edge k) it reads k.
  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // ---------------- register-file agent ----------------
  bit                ack_on    = 1'b1;  // answer accesses at all
  int                ack_delay = 0;     // access cycle index that carries reg_ack
  bit                ack_err   = 1'b0;  // reg_err value sent with reg_ack
  bit                ack_idle  = 1'b0;  // pulse a stray reg_ack while no access is open
  logic [DATA_W-1:0] rf_mem [N_WORDS];
  int                n_wr_starts = 0;
  int                n_rd_starts = 0;
  int                last_en_cycles = 0;
  int unsigned       last_start_cyc = 0;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;
  logic [STRB_W-1:0] last_wstrb;

  initial begin : reg_agent
    int acc_cnt;
    int cur_en;
    int idx;
    acc_cnt = 0;
    cur_en  = 0;
    reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
    for (int i = 0; i < N_WORDS; i++) rf_mem[i] = '0;
    forever begin
      @(negedge aclk);
      reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
      if (reg_wr_en || reg_rd_en) begin
        if (acc_cnt == 0) begin
          if (reg_wr_en) n_wr_starts++;
          else           n_rd_starts++;
          last_addr      = reg_addr;
          last_wdata     = reg_wdata;
          last_wstrb     = reg_wstrb;
          last_start_cyc = cyc;
        end
        cur_en++;
        if (ack_on && acc_cnt == ack_delay) begin
          idx     = int'(reg_addr[7:2]);
          reg_ack = 1'b1;
          reg_err = ack_err;
          if (reg_rd_en) begin
            reg_rdata = rf_mem[idx];
          end else if (!ack_err) begin
            for (int b = 0; b < STRB_W; b++)
              if (reg_wstrb[b]) rf_mem[idx][8*b +: 8] = reg_wdata[8*b +: 8];
          end
        end
        acc_cnt++;
      end else begin
        if (cur_en > 0) last_en_cycles = cur_en;
        cur_en  = 0;
        acc_cnt = 0;
        if (ack_idle) begin
          reg_ack = 1'b1; reg_err = 1'b1; reg_rdata = '1;
        end
      end
    end
  end

  // ---------------- reference model of the register space ----------------
  logic [DATA_W-1:0] ref_mem [N_WORDS];

  function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] addr, input bit err);
    return (addr >= ADDR_W'(SPACE) || err) ? 2'b10 : 2'b00;
  endfunction

  task automatic ref_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [STRB_W-1:0] strb);
    int idx;
    idx = int'(addr) / STRB_W;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  // ---------------- AXI master tasks ----------------
  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [STRB_W-1:0] strb, input int w_lead, input int b_hold,
                           output logic [1:0] resp, output int unsigned hs_cyc,
                           output int unsigned b_cyc, output bit stable);
    bit aw_done, w_done, aw_fire, w_fire;
    int lead, guard;
    logic [1:0] first_resp;
    aw_done = 0; w_done = 0; lead = w_lead; guard = 0;
    resp = 2'bxx; hs_cyc = 0; b_cyc = 0; stable = 1;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_wvalid = 1'b1; s_axi_awvalid = (lead == 0);
    while (!(aw_done && w_done) && guard < 100) begin
      #1;
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      if (aw_fire || w_fire) hs_cyc = cyc;
      step();
      if (aw_fire) begin s_axi_awvalid = 1'b0; aw_done = 1; end
      if (w_fire)  begin s_axi_wvalid  = 1'b0; w_done  = 1; end
      if (lead > 0) lead--;
      if (lead == 0 && !aw_done) s_axi_awvalid = 1'b1;
      guard++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("wr_addr_data_accepted", 64'(aw_done && w_done), 64'd1);
    guard = 0;
    while (s_axi_bvalid !== 1'b1 && guard < 100) begin step(); guard++; end
    check("wr_bvalid_seen", 64'(s_axi_bvalid), 64'd1);
    b_cyc = cyc; first_resp = s_axi_bresp;
    for (int i = 0; i < b_hold; i++) begin
      step();
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== first_resp) stable = 0;
    end
    s_axi_bready = 1'b1;
    resp = s_axi_bresp;
    step();
    s_axi_bready = 1'b0;
    if (s_axi_bvalid !== 1'b0) stable = 0;
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] addr, input int r_hold,
                          output logic [DATA_W-1:0] data, output logic [1:0] resp,
                          output int unsigned hs_cyc, output int unsigned r_cyc, output bit stable);
    bit ar_fire, ar_done;
    int guard;
    logic [DATA_W-1:0] first_data;
    logic [1:0] first_resp;
    ar_done = 0; guard = 0; data = 'x; resp = 2'bxx; hs_cyc = 0; r_cyc = 0; stable = 1;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    while (!ar_done && guard < 100) begin
      #1;
      ar_fire = s_axi_arvalid && s_axi_arready;
      if (ar_fire) hs_cyc = cyc;
      step();
      if (ar_fire) begin s_axi_arvalid = 1'b0; ar_done = 1; end
      guard++;
    end
    s_axi_arvalid = 1'b0;
    check("rd_addr_accepted", 64'(ar_done), 64'd1);
    guard = 0;
    while (s_axi_rvalid !== 1'b1 && guard < 100) begin step(); guard++; end
    check("rd_rvalid_seen", 64'(s_axi_rvalid), 64'd1);
    r_cyc = cyc; first_data = s_axi_rdata; first_resp = s_axi_rresp;
    for (int i = 0; i < r_hold; i++) begin
      step();
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== first_data || s_axi_rresp !== first_resp)
        stable = 0;
    end
    s_axi_rready = 1'b1;
    data = s_axi_rdata; resp = s_axi_rresp;
    step();
    s_axi_rready = 1'b0;
    if (s_axi_rvalid !== 1'b0) stable = 0;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                              s_axi_rvalid, reg_wr_en, reg_rd_en}), 64'd0);
    check({tag, "_resp"}, 64'({s_axi_bresp, s_axi_rresp}), 64'd0);
    check({tag, "_rdata"}, 64'(s_axi_rdata), 64'd0);
    check({tag, "_regport"}, 64'({reg_addr, reg_wstrb}), 64'd0);
    check({tag, "_wdata"}, 64'(reg_wdata), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed and random sequence ----------------
  initial begin : main
    logic [1:0]        resp, bresp2;
    logic [DATA_W-1:0] rdata, data;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strb;
    int unsigned       hs, rc, b_cyc, ar_cyc;
    bit                stable, is_wr, err, in_range, quiet, ar_blocked;
    bit                aw_done, w_done, ar_done, b_done, r_done;
    int                w0, r0, guard, idx;

    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    for (int i = 0; i < N_WORDS; i++) ref_mem[i] = '0;

    repeat (3) step();
    check_quiet_outputs("reset");
    areset = 1'b0;
    step();

    // 1: AW+W same cycle, ack in the first access cycle
    ack_delay = 0; ack_err = 0; w0 = n_wr_starts;
    axi_write('h04, 'hA5A5_0001, 'hF, 0, 0, resp, hs, b_cyc, stable);
    ref_write('h04, 'hA5A5_0001, 'hF);
    check("w1_bresp", 64'(resp), 64'(exp_resp('h04, 0)));
    check("w1_wr_starts", 64'(n_wr_starts - w0), 64'd1);
    check("w1_en_cycles", 64'(last_en_cycles), 64'd1);
    check("w1_en_latency", 64'(last_start_cyc - hs), 64'd1);
    check("w1_bvalid_latency", 64'(b_cyc - hs), 64'd2);
    check("w1_reg_addr", 64'(last_addr), 64'h04);
    check("w1_reg_wdata", 64'(last_wdata), 64'hA5A5_0001);

    // 2: W three cycles ahead of AW
    ack_delay = 1; w0 = n_wr_starts;
    axi_write('h10, 'hCAFE_F00D, 'hF, 3, 1, resp, hs, b_cyc, stable);
    ref_write('h10, 'hCAFE_F00D, 'hF);
    check("w2_bresp", 64'(resp), 64'd0);
    check("w2_wr_starts", 64'(n_wr_starts - w0), 64'd1);
    check("w2_reg_addr", 64'(last_addr), 64'h10);
    check("w2_single_b", 64'(stable), 64'd1);

    // 3: read 'h08 with ack after 4 cycles, rready held low 5 cycles
    axi_write('h08, 'h1234_5678, 'hF, 0, 0, resp, hs, b_cyc, stable);
    ref_write('h08, 'h1234_5678, 'hF);
    ack_delay = 4; r0 = n_rd_starts;
    axi_read('h08, 5, rdata, resp, hs, rc, stable);
    check("r3_rdata", 64'(rdata), 64'(ref_mem[2]));
    check("r3_rresp", 64'(resp), 64'd0);
    check("r3_rvalid_stable", 64'(stable), 64'd1);
    check("r3_rd_starts", 64'(n_rd_starts - r0), 64'd1);
    check("r3_en_cycles", 64'(last_en_cycles), 64'd5);

    // 4: AW+W and AR offered in the same cycle; the read sees the new data
    ack_delay = 0; data = 'h0BAD_BEEF;
    s_axi_awaddr = 'h20; s_axi_wdata = data; s_axi_wstrb = 'hF; s_axi_araddr = 'h20;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    #1;
    ar_blocked = (s_axi_arready === 1'b0);
    aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
    b_cyc = 0; ar_cyc = 0; guard = 0; bresp2 = 2'bxx; resp = 2'bxx; rdata = 'x;
    while (!(b_done && r_done) && guard < 200) begin
      #1;
      if (s_axi_awvalid && s_axi_awready) aw_done = 1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1;
      if (s_axi_arvalid && s_axi_arready) begin ar_done = 1; ar_cyc = cyc; end
      if (s_axi_bvalid && !b_done) begin b_done = 1; b_cyc = cyc; bresp2 = s_axi_bresp; end
      if (s_axi_rvalid && !r_done) begin r_done = 1; resp = s_axi_rresp; rdata = s_axi_rdata; end
      step();
      if (aw_done) s_axi_awvalid = 1'b0;
      if (w_done)  s_axi_wvalid  = 1'b0;
      if (ar_done) s_axi_arvalid = 1'b0;
      guard++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    ref_write('h20, data, 'hF);
    check("c4_ar_blocked", 64'(ar_blocked), 64'd1);
    check("c4_both_done", 64'(b_done && r_done), 64'd1);
    check("c4_ar_after_b", 64'(ar_done && ar_cyc > b_cyc), 64'd1);
    check("c4_bresp", 64'(bresp2), 64'd0);
    check("c4_rresp", 64'(resp), 64'd0);
    check("c4_rdata", 64'(rdata), 64'(ref_mem[8]));

    // 5: out-of-range accesses and an erroring register access
    r0 = n_rd_starts; w0 = n_wr_starts;
    axi_read('h100, 0, rdata, resp, hs, rc, stable);
    check("o5_rd_no_access", 64'(n_rd_starts - r0), 64'd0);
    check("o5_rresp", 64'(resp), 64'd2);
    check("o5_rdata", 64'(rdata), 64'd0);
    axi_write('h104, 'hFFFF_FFFF, 'hF, 1, 0, resp, hs, b_cyc, stable);
    check("o5_wr_no_access", 64'(n_wr_starts - w0), 64'd0);
    check("o5_bresp", 64'(resp), 64'd2);
    ack_err = 1; ack_delay = 2;
    axi_read('h0C, 1, rdata, resp, hs, rc, stable);
    check("e5_rresp", 64'(resp), 64'd2);
    ack_err = 0;

    // 6: stray reg_ack while idle produces nothing
    ack_idle = 1; quiet = 1;
    repeat (4) begin
      step();
      if (s_axi_bvalid || s_axi_rvalid || reg_wr_en || reg_rd_en) quiet = 0;
    end
    ack_idle = 0;
    step();
    check("i6_stray_ack_ignored", 64'(quiet), 64'd1);

    // 7: randomized mix against the register-space model
    for (int t = 0; t < 24; t++) begin
      is_wr     = 1'($urandom_range(0, 1));
      addr      = ADDR_W'($urandom_range(0, 'h13F));
      ack_delay = $urandom_range(0, 3);
      err       = ($urandom_range(0, 7) == 0);
      ack_err   = err;
      in_range  = addr < ADDR_W'(SPACE);
      idx       = int'(addr) / STRB_W;
      w0 = n_wr_starts; r0 = n_rd_starts;
      if (is_wr) begin
        data = $urandom;
        strb = STRB_W'($urandom_range(0, 15));
        axi_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2),
                  resp, hs, b_cyc, stable);
        check("rnd_bresp", 64'(resp), 64'(exp_resp(addr, err)));
        check("rnd_wr_starts", 64'(n_wr_starts - w0), 64'(in_range));
        if (in_range) begin
          check("rnd_wr_addr", 64'(last_addr), 64'(addr & ~ADDR_W'(STRB_W - 1)));
          check("rnd_wr_data", 64'({last_wstrb, last_wdata}), 64'({strb, data}));
          if (!err) ref_write(addr, data, strb);
        end
      end else begin
        axi_read(addr, $urandom_range(0, 2), rdata, resp, hs, rc, stable);
        check("rnd_rresp", 64'(resp), 64'(exp_resp(addr, err)));
        check("rnd_rd_starts", 64'(n_rd_starts - r0), 64'(in_range));
        if (!in_range) check("rnd_rdata_oor", 64'(rdata), 64'd0);
        else if (!err) check("rnd_rdata", 64'(rdata), 64'(ref_mem[idx]));
      end
    end
    ack_err = 0;

`ifdef AXILITE_SLV_TIMEOUT_EN
    // 8: no ack -> access abandoned after TIMEOUT_CYC cycles
    ack_on = 0;
    axi_read('h0C, 0, rdata, resp, hs, rc, stable);
    check("t8_rresp", 64'(resp), 64'd2);
    check("t8_rdata", 64'(rdata), 64'd0);
    check("t8_en_cycles", 64'(last_en_cycles), 64'(TIMEOUT_CYC));
    ack_on = 1;
`endif

    // 9: reset while a read access is open
    ack_on = 0; guard = 0; ar_done = 0;
    s_axi_araddr = 'h18; s_axi_arvalid = 1'b1;
    while (!ar_done && guard < 20) begin
      #1; ar_done = s_axi_arready; step(); guard++;
    end
    s_axi_arvalid = 1'b0;
    check("x9_ar_accepted", 64'(ar_done), 64'd1);
    step(); step();
    check("x9_rd_en_open", 64'(reg_rd_en), 64'd1);
    areset = 1'b1;
    step();
    check_quiet_outputs("x9_mid_reset");
    areset = 1'b0; ack_on = 1; ack_delay = 0;
    step();
    axi_read('h04, 0, rdata, resp, hs, rc, stable);
    check("x9_recover_rdata", 64'(rdata), 64'(ref_mem[1]));
    check("x9_recover_rresp", 64'(resp), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
